// File: rtl/lcd_pkg.sv
// Shared command codes and command-state encoding for the LCD panel responder.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMRD   = 8'h2E;
  localparam logic [7:0] CMD_RDID    = 8'hD3;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_RAMRD,
    S_RDID
  } cmd_state_e;

endpackage

// File: rtl/lcd_win_addr_gen.sv
// Column/page window registers and the raster-order pixel pointer inside that window.
// The linear address is row_base + col, where row_base steps by H_RES per page.
module lcd_win_addr_gen
  import lcd_pkg::*;
#(
  parameter int H_RES = 480,
  parameter int V_RES = 800,
  parameter int FB_AW = 19,
  parameter int CW    = 9,
  parameter int PW    = 10
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             col_set,
  input  logic [CW-1:0]    col_start,
  input  logic [CW-1:0]    col_end,
  input  logic             page_set,
  input  logic [PW-1:0]    page_start,
  input  logic [PW-1:0]    page_end,
  input  logic             load_start,
  input  logic             advance,
  output logic [FB_AW-1:0] addr
);

  logic [CW-1:0]    sc, ec, col;
  logic [PW-1:0]    sp, ep, page;
  logic [FB_AW-1:0] sp_base, row_base;

  assign addr = row_base + FB_AW'(col);

  // Window bounds; sp_base caches the row offset of the window's first page.
  // The product is by a constant and only taken when a new page window is accepted.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sc      <= '0;
      ec      <= CW'(H_RES - 1);
      sp      <= '0;
      ep      <= PW'(V_RES - 1);
      sp_base <= '0;
    end else begin
      if (col_set) begin
        sc <= col_start;
        ec <= col_end;
      end
      if (page_set) begin
        sp      <= page_start;
        ep      <= page_end;
        sp_base <= FB_AW'(page_start) * FB_AW'(H_RES);
      end
    end
  end

  // Pixel pointer: restart at (SP,SC) or step in raster order, wrapping inside the window.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      col      <= '0;
      page     <= '0;
      row_base <= '0;
    end else if (load_start) begin
      col      <= sc;
      page     <= sp;
      row_base <= sp_base;
    end else if (advance) begin
      if (col == ec) begin
        col <= sc;
        if (page == ep) begin
          page     <= sp;
          row_base <= sp_base;
        end else begin
          page     <= page + 1'b1;
          row_base <= row_base + FB_AW'(H_RES);
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_panel_responder.sv
// Panel-side responder for the 8080-style 16-bit LCD bus: command decode,
// address window, pixel streaming into the frame buffer, RDDID and RAMRD answers.
module lcd_panel_responder
  import lcd_pkg::*;
#(
  parameter int          H_RES  = 480,
  parameter int          V_RES  = 800,
  parameter int          FB_AW  = 19,
  parameter logic [23:0] LCD_ID = 24'h009341
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             lcd_cs,
  input  logic             lcd_rs,
  input  logic             lcd_wr,
  input  logic             lcd_rd,
  input  logic [15:0]      lcd_data_i,
  output logic [15:0]      lcd_data_o,
  output logic             lcd_data_oe,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_waddr,
  output logic [15:0]      fb_wdata,
  output logic             fb_re,
  output logic [FB_AW-1:0] fb_raddr,
  input  logic [15:0]      fb_rdata,
  output logic             disp_on
);

  localparam int CW = $clog2(H_RES);
  localparam int PW = $clog2(V_RES);

  cmd_state_e       state;
  logic             cs_q, rs_q, wr_q, rd_q, wr_qq, rd_qq;
  logic [15:0]      data_q;
  logic             wr_ev, cmd_ev, dat_ev, rd_st, rd_end;
  logic [7:0]       cmd_code;
  logic [2:0]       byte_idx;
  logic [7:0]       tmp_b0, tmp_b1, tmp_b2;
  logic [15:0]      win_start, win_end;
  logic             col_ok, page_ok;
  logic             ag_load, ag_adv, col_set, page_set;
  logic [FB_AW-1:0] ag_addr;
  logic             rd_first, fetch_pend, pf_load;
  logic [15:0]      pf_data;

  // Bus inputs registered once, strobes registered a second time for edge detection.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cs_q   <= 1'b1;
      rs_q   <= 1'b0;
      wr_q   <= 1'b1;
      rd_q   <= 1'b1;
      wr_qq  <= 1'b1;
      rd_qq  <= 1'b1;
      data_q <= '0;
    end else begin
      cs_q   <= lcd_cs;
      rs_q   <= lcd_rs;
      wr_q   <= lcd_wr;
      rd_q   <= lcd_rd;
      wr_qq  <= wr_q;
      rd_qq  <= rd_q;
      data_q <= lcd_data_i;
    end
  end

  assign wr_ev    = wr_q & ~wr_qq & ~cs_q;
  assign cmd_ev   = wr_ev & ~rs_q;
  assign dat_ev   = wr_ev & rs_q;
  assign rd_st    = ~rd_q & rd_qq & ~cs_q & wr_q;
  assign rd_end   = rd_q & ~rd_qq;
  assign cmd_code = data_q[7:0];

  // Window candidate assembled on the fourth parameter byte; rejected windows are never loaded.
  assign win_start = {tmp_b0, tmp_b1};
  assign win_end   = {tmp_b2, data_q[7:0]};
  assign col_ok    = (win_start <= win_end) && (win_end < 16'(H_RES));
  assign page_ok   = (win_start <= win_end) && (win_end < 16'(V_RES));

  // Address-generator control decoded from the current bus event.
  always_comb begin
    ag_load  = cmd_ev && ((cmd_code == CMD_RAMWR) || (cmd_code == CMD_RAMRD));
    ag_adv   = (dat_ev && (state == S_RAMWR)) ||
               (rd_st && (state == S_RAMRD) && !rd_first);
    col_set  = dat_ev && (state == S_CASET) && (byte_idx == 3'd3) && col_ok;
    page_set = dat_ev && (state == S_PASET) && (byte_idx == 3'd3) && page_ok;
  end

  lcd_win_addr_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .FB_AW (FB_AW),
    .CW    (CW),
    .PW    (PW)
  ) u_addr_gen (
    .pclk       (pclk),
    .rst        (rst),
    .col_set    (col_set),
    .col_start  (win_start[CW-1:0]),
    .col_end    (win_end[CW-1:0]),
    .page_set   (page_set),
    .page_start (win_start[PW-1:0]),
    .page_end   (win_end[PW-1:0]),
    .load_start (ag_load),
    .advance    (ag_adv),
    .addr       (ag_addr)
  );

  // Command FSM with registered bus, frame-buffer and display outputs.
  // RAMRD: the dummy read fetches the current pixel; every later read returns the
  // prefetched pixel, advances, and fetches the next one a cycle later.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_idx    <= '0;
      tmp_b0      <= '0;
      tmp_b1      <= '0;
      tmp_b2      <= '0;
      lcd_data_o  <= '0;
      lcd_data_oe <= 1'b0;
      fb_we       <= 1'b0;
      fb_waddr    <= '0;
      fb_wdata    <= '0;
      fb_re       <= 1'b0;
      fb_raddr    <= '0;
      disp_on     <= 1'b0;
      rd_first    <= 1'b0;
      fetch_pend  <= 1'b0;
      pf_load     <= 1'b0;
      pf_data     <= '0;
    end else begin
      fb_we   <= 1'b0;
      fb_re   <= 1'b0;
      pf_load <= fb_re;
      if (pf_load) pf_data <= fb_rdata;
      if (fetch_pend) begin
        fb_re      <= 1'b1;
        fb_raddr   <= ag_addr;
        fetch_pend <= 1'b0;
      end

      if (cmd_ev) begin
        byte_idx <= '0;
        rd_first <= 1'b0;
        case (cmd_code)
          CMD_CASET: state <= S_CASET;
          CMD_PASET: state <= S_PASET;
          CMD_RAMWR: state <= S_RAMWR;
          CMD_RAMRD: begin
            state    <= S_RAMRD;
            rd_first <= 1'b1;
          end
          CMD_RDID: state <= S_RDID;
          CMD_DISPON: begin
            disp_on <= 1'b1;
            state   <= S_IDLE;
          end
          CMD_DISPOFF: begin
            disp_on <= 1'b0;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (dat_ev) begin
        case (state)
          S_CASET, S_PASET: begin
            if (byte_idx != 3'd4) begin
              case (byte_idx[1:0])
                2'd0:    tmp_b0 <= data_q[7:0];
                2'd1:    tmp_b1 <= data_q[7:0];
                2'd2:    tmp_b2 <= data_q[7:0];
                default: ;
              endcase
              byte_idx <= byte_idx + 1'b1;
            end
          end
          S_RAMWR: begin
            fb_we    <= 1'b1;
            fb_waddr <= ag_addr;
            fb_wdata <= data_q;
          end
          default: ;
        endcase
      end

      if (rd_st) begin
        lcd_data_oe <= 1'b1;
        lcd_data_o  <= '0;
        case (state)
          S_RAMRD: begin
            if (rd_first) begin
              rd_first <= 1'b0;
              fb_re    <= 1'b1;
              fb_raddr <= ag_addr;
            end else begin
              lcd_data_o <= pf_data;
              fetch_pend <= 1'b1;
            end
          end
          S_RDID: begin
            case (byte_idx)
              3'd1:    lcd_data_o <= {8'h00, LCD_ID[23:16]};
              3'd2:    lcd_data_o <= {8'h00, LCD_ID[15:8]};
              3'd3:    lcd_data_o <= {8'h00, LCD_ID[7:0]};
              default: ;
            endcase
            if (byte_idx != 3'd4) byte_idx <= byte_idx + 1'b1;
          end
          default: ;
        endcase
      end else if (rd_end) begin
        lcd_data_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Bench for lcd_panel_responder: a table of bus operations with a write/read scoreboard,
// followed by hand sequences for ignored strobes, RAMRD prefetch and reset during a read.
module tb_lcd_panel_responder;
  import lcd_pkg::*;

  localparam int FB_AW = 19;

  logic             pclk, rst;
  logic             lcd_cs, lcd_rs, lcd_wr, lcd_rd;
  logic [15:0]      lcd_data_i, lcd_data_o;
  logic             lcd_data_oe;
  logic             fb_we, fb_re, disp_on;
  logic [FB_AW-1:0] fb_waddr, fb_raddr;
  logic [15:0]      fb_wdata, fb_rdata;

  lcd_panel_responder #(
    .H_RES  (480),
    .V_RES  (800),
    .FB_AW  (FB_AW),
    .LCD_ID (24'h009341)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .lcd_cs      (lcd_cs),
    .lcd_rs      (lcd_rs),
    .lcd_wr      (lcd_wr),
    .lcd_rd      (lcd_rd),
    .lcd_data_i  (lcd_data_i),
    .lcd_data_o  (lcd_data_o),
    .lcd_data_oe (lcd_data_oe),
    .fb_we       (fb_we),
    .fb_waddr    (fb_waddr),
    .fb_wdata    (fb_wdata),
    .fb_re       (fb_re),
    .fb_raddr    (fb_raddr),
    .fb_rdata    (fb_rdata),
    .disp_on     (disp_on)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef enum {K_CMD, K_WR, K_RD, K_DISP} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] d;
    bit          chk;
    logic [31:0] exp;
  } op_t;
  typedef struct {
    logic [FB_AW-1:0] a;
    logic [15:0]      d;
  } wexp_t;

  op_t              ops[$];
  wexp_t            wq[$];
  logic [15:0]      rq[$];
  logic [FB_AW-1:0] raq[$];
  logic [15:0]      fb_mem [0:4095];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               we_cnt = 0;
  int               re_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Frame-buffer model: read data appears one cycle after fb_re.
  always @(posedge pclk) begin
    if (fb_re) fb_rdata <= fb_mem[fb_raddr[11:0]];
  end

  // Scoreboard side: compare every frame-buffer access against the queued expectation.
  always @(negedge pclk) begin
    if (!rst) begin
      if (fb_we) begin
        we_cnt++;
        if (wq.size() == 0) check("unexpected fb_we addr", 32'(fb_waddr), 32'hFFFF_FFFF);
        else begin
          wexp_t e;
          e = wq.pop_front();
          check("fb_waddr", 32'(fb_waddr), 32'(e.a));
          check("fb_wdata", 32'(fb_wdata), 32'(e.d));
        end
      end
      if (fb_re) begin
        re_cnt++;
        if (raq.size() == 0) check("unexpected fb_re addr", 32'(fb_raddr), 32'hFFFF_FFFF);
        else check("fb_raddr", 32'(fb_raddr), 32'(raq.pop_front()));
      end
    end
  end

  task automatic bus_write(input logic rs, input logic [15:0] d);
    lcd_cs = 1'b0;
    lcd_rs = rs;
    lcd_data_i = d;
    lcd_wr = 1'b0;
    repeat (2) @(posedge pclk);
    #1 lcd_wr = 1'b1;
    repeat (3) @(posedge pclk);
    #1 lcd_cs = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_read(input string nm);
    logic [15:0] v;
    lcd_cs = 1'b0;
    lcd_rs = 1'b1;
    lcd_rd = 1'b0;
    repeat (3) @(posedge pclk);
    #1 v = lcd_data_o;
    check({nm, " oe during rd"}, 32'(lcd_data_oe), 32'd1);
    if (rq.size() > 0) check({nm, " data"}, 32'(v), 32'(rq.pop_front()));
    lcd_rd = 1'b1;
    @(posedge pclk);
    #1 check({nm, " oe held"}, 32'(lcd_data_oe), 32'd1);
    @(posedge pclk);
    #1 check({nm, " oe released"}, 32'(lcd_data_oe), 32'd0);
    lcd_cs = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
  endtask

  task automatic add(input kind_e k, input logic [15:0] d, input bit c, input logic [31:0] e);
    op_t o;
    o.kind = k;
    o.d = d;
    o.chk = c;
    o.exp = e;
    ops.push_back(o);
  endtask

  initial begin
    int we_before;
    wexp_t w;
    rst = 1'b1;
    lcd_cs = 1'b1;
    lcd_rs = 1'b1;
    lcd_wr = 1'b1;
    lcd_rd = 1'b1;
    lcd_data_i = '0;
    fb_rdata = '0;
    for (int i = 0; i < 4096; i++) fb_mem[i] = '0;

    repeat (3) @(posedge pclk);
    #1;
    check("reset outputs", {lcd_data_o, 8'h0, lcd_data_oe, fb_we, fb_re, disp_on, 4'h0},
          32'h0);
    check("reset addrs", {fb_waddr[15:0], fb_raddr[15:0]}, 32'h0);
    check("reset wdata", 32'(fb_wdata), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge pclk);
    #1;

    // Window cols 10..12, pages 5..6, then a stream of pixels.
    add(K_CMD, 16'h002A, 0, 0);
    add(K_WR, 16'd0, 0, 0); add(K_WR, 16'd10, 0, 0);
    add(K_WR, 16'd0, 0, 0); add(K_WR, 16'd12, 0, 0);
    add(K_CMD, 16'h002B, 0, 0);
    add(K_WR, 16'd0, 0, 0); add(K_WR, 16'd5, 0, 0);
    add(K_WR, 16'd0, 0, 0); add(K_WR, 16'd6, 0, 0);
    add(K_CMD, 16'h002C, 0, 0);
    add(K_WR, 16'hA001, 1, 2410); add(K_WR, 16'hA002, 1, 2411);
    add(K_WR, 16'hA003, 1, 2412); add(K_WR, 16'hA004, 1, 2890);
    add(K_WR, 16'hA005, 1, 2891); add(K_WR, 16'hA006, 1, 2892);
    add(K_WR, 16'hA007, 1, 2410);
    add(K_RD, 16'h0, 1, 32'h0000);
    // start > end: window must stay 10..12 / 5..6.
    add(K_CMD, 16'h002A, 0, 0);
    add(K_WR, 16'h01, 0, 0); add(K_WR, 16'h00, 0, 0);
    add(K_WR, 16'h00, 0, 0); add(K_WR, 16'h0A, 0, 0);
    add(K_CMD, 16'h002C, 0, 0);
    add(K_WR, 16'hB001, 1, 2410); add(K_WR, 16'hB002, 1, 2411);
    add(K_WR, 16'hB003, 1, 2412); add(K_WR, 16'hB004, 1, 2890);
    // Read ID, then an ignored data write in RDID.
    add(K_CMD, 16'h00D3, 0, 0);
    add(K_RD, 16'h0, 1, 32'h0000); add(K_RD, 16'h0, 1, 32'h0000);
    add(K_RD, 16'h0, 1, 32'h0093); add(K_RD, 16'h0, 1, 32'h0041);
    add(K_RD, 16'h0, 1, 32'h0000);
    add(K_WR, 16'h5555, 0, 0);
    add(K_CMD, 16'h0029, 0, 0); add(K_DISP, 16'h0, 1, 1);
    add(K_CMD, 16'h0028, 0, 0); add(K_DISP, 16'h0, 1, 0);
    add(K_CMD, 16'h0029, 0, 0); add(K_DISP, 16'h0, 1, 1);
    add(K_CMD, 16'h002C, 0, 0);

    foreach (ops[i]) begin
      case (ops[i].kind)
        K_CMD: bus_write(1'b0, ops[i].d);
        K_WR: begin
          if (ops[i].chk) begin
            w.a = FB_AW'(ops[i].exp);
            w.d = ops[i].d;
            wq.push_back(w);
          end
          bus_write(1'b1, ops[i].d);
        end
        K_RD: begin
          rq.push_back(ops[i].exp[15:0]);
          bus_read($sformatf("op%0d read", i));
        end
        K_DISP: check($sformatf("op%0d disp_on", i), 32'(disp_on), ops[i].exp);
        default: ;
      endcase
    end

    // Write strobe with cs high: ignored.
    we_before = we_cnt;
    lcd_cs = 1'b1; lcd_rs = 1'b1; lcd_data_i = 16'h1234; lcd_wr = 1'b0;
    repeat (2) @(posedge pclk);
    #1 lcd_wr = 1'b1;
    repeat (4) @(posedge pclk);
    #1 check("cs high write ignored", 32'(we_cnt), 32'(we_before));

    // rd pulse while wr is low: no bus drive; wr released with cs high afterwards.
    lcd_cs = 1'b0; lcd_wr = 1'b0;
    @(posedge pclk);
    #1 lcd_rd = 1'b0;
    repeat (3) @(posedge pclk);
    #1 check("rd during wr oe", 32'(lcd_data_oe), 32'd0);
    lcd_rd = 1'b1;
    repeat (2) @(posedge pclk);
    #1 lcd_cs = 1'b1;
    @(posedge pclk);
    #1 lcd_wr = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    check("rd during wr no write", 32'(we_cnt), 32'(we_before));
    check("rd during wr oe after", 32'(lcd_data_oe), 32'd0);

    // RAMRD over window (0..1, 0..0).
    bus_write(1'b0, 16'h002A);
    bus_write(1'b1, 16'h00); bus_write(1'b1, 16'h00);
    bus_write(1'b1, 16'h00); bus_write(1'b1, 16'h01);
    bus_write(1'b0, 16'h002B);
    bus_write(1'b1, 16'h00); bus_write(1'b1, 16'h00);
    bus_write(1'b1, 16'h00); bus_write(1'b1, 16'h00);
    fb_mem[0] = 16'hF800;
    fb_mem[1] = 16'h07E0;
    re_cnt = 0;
    raq.push_back('0); raq.push_back(FB_AW'(1)); raq.push_back('0);
    bus_write(1'b0, 16'h002E);
    rq.push_back(16'h0000); bus_read("ramrd dummy");
    rq.push_back(16'hF800); bus_read("ramrd pix0");
    rq.push_back(16'h07E0); bus_read("ramrd pix1");
    check("fb_re pulses", 32'(re_cnt), 32'd3);

    // Reset in the middle of a RAMRD read.
    bus_write(1'b0, 16'h002E);
    raq.push_back('0);
    lcd_cs = 1'b0; lcd_rs = 1'b1; lcd_rd = 1'b0;
    repeat (3) @(posedge pclk);
    #1 check("oe before rst", 32'(lcd_data_oe), 32'd1);
    #2 rst = 1'b1;
    #1 check("oe async clear", 32'(lcd_data_oe), 32'd0);
    check("state after rst", 32'(dut.state), 32'(S_IDLE));
    lcd_rd = 1'b1; lcd_cs = 1'b1;
    repeat (2) @(posedge pclk);
    #1 rst = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    bus_write(1'b0, 16'h002C);
    for (int i = 0; i < 3; i++) begin
      w.a = FB_AW'(i);
      w.d = 16'hC000 + 16'(i);
      wq.push_back(w);
      bus_write(1'b1, w.d);
    end
    repeat (3) @(posedge pclk);
    #1;
    check("write queue drained", 32'(wq.size()), 32'd0);
    check("read addr queue drained", 32'(raq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
